misr_sig: RTL and testbench



---
 rtl/misr_pkg.sv | 15 +
 rtl/misr_step.sv | 15 +
 rtl/misr_sig.sv | 112 +++++++++++
 tb/tb_misr_sig.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature block.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  // Wide enough for the largest legal WIDTH; instances slice off what they need.
  localparam logic [63:0] DEFAULT_POLY = 64'h0000_0000_0001_0811;

  localparam int unsigned COUNT_WIDTH = 16;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR update: shift, inject data, fold the MSB back through POLY.
module misr_step
  import misr_pkg::*;
#(
  parameter int unsigned          WIDTH = 32,
  parameter logic [WIDTH-1:0]     POLY  = DEFAULT_POLY[WIDTH-1:0]
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {sig[WIDTH-2:0], 1'b0} ^ d ^ (POLY & {WIDTH{sig[WIDTH-1]}});

endmodule

// File: rtl/misr_sig.sv
// MISR response compactor with run control and optional golden compare.
// Define MISR_SIG_COMPARE_EN to build the golden comparator; otherwise pass is tied low.
module misr_sig
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] POLY   = DEFAULT_POLY[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int unsigned      LENGTH = 1024
) (
  input  logic                   CK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   data_valid,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [WIDTH-1:0]       golden,
  output logic [WIDTH-1:0]       signature,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] LastIdx = COUNT_WIDTH'(LENGTH - 1);

  misr_state_e            state_q;
  logic [WIDTH-1:0]       sig_q;
  logic [WIDTH-1:0]       sig_nxt;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   busy_q;
  logic                   done_q;

  misr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .sig (sig_q),
    .d   (data_in),
    .nxt (sig_nxt)
  );

  // abort outranks start, and start outranks data_valid, in every state.
  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= RUN;
            sig_q   <= SEED;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (start) begin
            sig_q   <= SEED;
            count_q <= '0;
          end else if (data_valid) begin
            sig_q   <= sig_nxt;
            count_q <= count_q + COUNT_WIDTH'(1);
            if (count_q == LastIdx) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q <= RUN;
            sig_q   <= SEED;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign signature = sig_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MISR_SIG_COMPARE_EN
  assign pass = done_q && (sig_q == golden);
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_misr_sig.sv
// Scoreboard bench for misr_sig: three instances (A: SEED 0/LENGTH 1, B: SEED 8000_0000/LENGTH 4,
// C: SEED 8000_0000/LENGTH 1) share stimulus; expectations are hand-computed per instance.
module tb_misr_sig;

  logic        CK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] golden = '0;

  logic [31:0] sig_a, sig_b, sig_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;

  always #5 CK = ~CK;

  misr_sig #(.WIDTH(32), .SEED(32'h0000_0000), .LENGTH(1)) dut_a (
    .CK(CK), .RESET(RESET), .start(start), .abort(abort), .data_valid(data_valid),
    .data_in(data_in), .golden(golden), .signature(sig_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .count(cnt_a)
  );

  misr_sig #(.WIDTH(32), .SEED(32'h8000_0000), .LENGTH(4)) dut_b (
    .CK(CK), .RESET(RESET), .start(start), .abort(abort), .data_valid(data_valid),
    .data_in(data_in), .golden(golden), .signature(sig_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .count(cnt_b)
  );

  misr_sig #(.WIDTH(32), .SEED(32'h8000_0000), .LENGTH(1)) dut_c (
    .CK(CK), .RESET(RESET), .start(start), .abort(abort), .data_valid(data_valid),
    .data_in(data_in), .golden(golden), .signature(sig_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .count(cnt_c)
  );

  typedef struct {
    int          id;
    int          sel;
    logic [31:0] sig;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        pass;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  // p is the pass value when the comparator is built.
  task automatic exp(input int sel, input logic [31:0] s, input logic [15:0] c,
                     input logic b, input logic d, input logic p);
    exp_t e;
    e.id = step_id; e.sel = sel; e.sig = s; e.cnt = c; e.busy = b; e.done = d;
`ifdef MISR_SIG_COMPARE_EN
    e.pass = p;
`else
    e.pass = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic a, input logic v, input logic [31:0] d,
                       input logic [31:0] g);
    @(negedge CK);
    #1;
    RESET = 1'b0; start = s; abort = a; data_valid = v; data_in = d; golden = g;
    @(posedge CK);
    #2;
    step_id++;
  endtask

  // One idle edge, then RESET rises between clock edges so only the async path can act.
  task automatic pulse_reset();
    @(negedge CK);
    #1;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0;
    @(posedge CK);
    #1;
    RESET = 1'b1;
    #1;
    step_id++;
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] s;
    logic [15:0] c;
    logic        b, d, p;
    forever begin
      @(negedge CK);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin s = sig_a; c = cnt_a; b = busy_a; d = done_a; p = pass_a; end
          1:       begin s = sig_b; c = cnt_b; b = busy_b; d = done_b; p = pass_b; end
          default: begin s = sig_c; c = cnt_c; b = busy_c; d = done_c; p = pass_c; end
        endcase
        n_checks++;
        if (s !== e.sig || c !== e.cnt || b !== e.busy || d !== e.done || p !== e.pass) begin
          n_errors++;
          $display("FAIL step%0d_dut%0d: got sig=%h cnt=%0d busy=%b done=%b pass=%b, want sig=%h cnt=%0d busy=%b done=%b pass=%b",
                   e.id, e.sel, s, c, b, d, p, e.sig, e.cnt, e.busy, e.done, e.pass);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #1;
    exp(0, 32'h0000_0000, 16'd0, 1'b0, 1'b0, 1'b0);
    exp(1, 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1'b0);
    exp(2, 32'h8000_0000, 16'd0, 1'b0, 1'b0, 1'b0);

    // Single-word run from SEED 0; DONE ignores further data.
    drive(1, 0, 0, 32'h0, 32'h1);
    exp(0, 32'h0000_0000, 16'd0, 1, 0, 0);
    exp(2, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h1, 32'h1);
    exp(0, 32'h0000_0001, 16'd1, 0, 1, 1);
    exp(2, 32'h0001_0810, 16'd1, 0, 1, 0);
    drive(0, 0, 1, 32'hffff_ffff, 32'h0);
    exp(0, 32'h0000_0001, 16'd1, 0, 1, 0);

    // MSB-set seed folds through POLY; golden and golden^1.
    drive(1, 0, 0, 32'h0, 32'h0001_0811);
    exp(2, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h0, 32'h0001_0811);
    exp(2, 32'h0001_0811, 16'd1, 0, 1, 1);
    drive(0, 0, 0, 32'h0, 32'h0001_0810);
    exp(2, 32'h0001_0811, 16'd1, 0, 1, 0);

    // LENGTH 4 with gapped data_valid.
    drive(1, 0, 0, 32'h0, 32'h0);
    exp(1, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h1, 32'h0);
    exp(1, 32'h0001_0810, 16'd1, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0);
    exp(1, 32'h0001_0810, 16'd1, 1, 0, 0);
    drive(0, 0, 1, 32'h2, 32'h0);
    exp(1, 32'h0002_1022, 16'd2, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0);
    exp(1, 32'h0002_1022, 16'd2, 1, 0, 0);
    drive(0, 0, 1, 32'h8000_0000, 32'h0);
    exp(1, 32'h8004_2044, 16'd3, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0);
    exp(1, 32'h8004_2044, 16'd3, 1, 0, 0);
    drive(0, 0, 1, 32'h0, 32'h0);
    exp(1, 32'h0009_4899, 16'd4, 0, 1, 0);
    drive(0, 0, 1, 32'hffff_ffff, 32'h0009_4899);
    exp(1, 32'h0009_4899, 16'd4, 0, 1, 1);

    // Start from DONE, then restart in RUN at count 3 with a discarded word.
    drive(1, 0, 0, 32'h0, 32'h0);
    exp(1, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h1, 32'h0);
    exp(1, 32'h0001_0810, 16'd1, 1, 0, 0);
    drive(0, 0, 1, 32'h2, 32'h0);
    exp(1, 32'h0002_1022, 16'd2, 1, 0, 0);
    drive(0, 0, 1, 32'h8000_0000, 32'h0);
    exp(1, 32'h8004_2044, 16'd3, 1, 0, 0);
    drive(1, 0, 1, 32'h0000_5555, 32'h0);
    exp(1, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h1, 32'h0);
    exp(1, 32'h0001_0810, 16'd1, 1, 0, 0);

    // Async reset mid-run at count 2.
    drive(0, 0, 1, 32'h2, 32'h0);
    exp(1, 32'h0002_1022, 16'd2, 1, 0, 0);
    pulse_reset();
    exp(0, 32'h0000_0000, 16'd0, 0, 0, 0);
    exp(1, 32'h8000_0000, 16'd0, 0, 0, 0);
    exp(2, 32'h8000_0000, 16'd0, 0, 0, 0);

    // First edge after release acts; then abort from DONE/RUN and start+abort.
    drive(1, 0, 0, 32'h0, 32'h1);
    exp(0, 32'h0000_0000, 16'd0, 1, 0, 0);
    exp(1, 32'h8000_0000, 16'd0, 1, 0, 0);
    drive(0, 0, 1, 32'h1, 32'h1);
    exp(0, 32'h0000_0001, 16'd1, 0, 1, 1);
    exp(1, 32'h0001_0810, 16'd1, 1, 0, 0);
    drive(1, 1, 0, 32'h0, 32'h1);
    exp(0, 32'h0000_0001, 16'd1, 0, 0, 0);
    exp(1, 32'h0001_0810, 16'd1, 0, 0, 0);
    drive(0, 0, 1, 32'h7, 32'h1);
    exp(0, 32'h0000_0001, 16'd1, 0, 0, 0);
    exp(1, 32'h0001_0810, 16'd1, 0, 0, 0);
    drive(1, 1, 0, 32'h0, 32'h1);
    exp(0, 32'h0000_0001, 16'd1, 0, 0, 0);
    exp(1, 32'h0001_0810, 16'd1, 0, 0, 0);

    @(negedge CK);
    #1;
    start = 1'b0; abort = 1'b0; data_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CK);
    @(posedge CK);
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
